// File: rtl/square_wave_duty_meter.sv
// Measures the high and low durations of an asynchronous square wave in clk cycles
// and reports each complete high+low period with a one-cycle valid pulse.
module square_wave_duty_meter #(
    parameter int CNT_WIDTH   = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 square_wave_i,
    output logic [CNT_WIDTH-1:0] on_count_o,
    output logic [CNT_WIDTH-1:0] off_count_o,
    output logic [CNT_WIDTH:0]   period_o,
    output logic                 valid_o,
    output logic                 stalled_o
);

    typedef enum logic [1:0] {
        IDLE,
        MEAS_HIGH,
        MEAS_LOW
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sDly;
    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;

    state_t                 r_state;
    state_t                 w_stateNext;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   w_cntNext;
    logic [CNT_WIDTH-1:0]   r_highLen;
    logic [CNT_WIDTH-1:0]   w_highLenNext;
    logic [CNT_WIDTH-1:0]   r_onCount;
    logic [CNT_WIDTH-1:0]   w_onCountNext;
    logic [CNT_WIDTH-1:0]   r_offCount;
    logic [CNT_WIDTH-1:0]   w_offCountNext;
    logic [CNT_WIDTH:0]     r_period;
    logic [CNT_WIDTH:0]     w_periodNext;
    logic                   r_valid;
    logic                   w_validNext;
    logic                   r_stalled;
    logic                   w_stalledNext;

    // Synchronizer resets high so an input already high at reset release is not seen as a rise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= '1;
            r_sDly <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], square_wave_i};
            r_sDly <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_sDly;
    assign w_fall = ~w_s & r_sDly;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_highLen  <= '0;
            r_onCount  <= '0;
            r_offCount <= '0;
            r_period   <= '0;
            r_valid    <= 1'b0;
            r_stalled  <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_cnt      <= w_cntNext;
            r_highLen  <= w_highLenNext;
            r_onCount  <= w_onCountNext;
            r_offCount <= w_offCountNext;
            r_period   <= w_periodNext;
            r_valid    <= w_validNext;
            r_stalled  <= w_stalledNext;
        end
    end

    // An edge always wins over saturation, so a count of exactly CNT_MAX is still recorded.
    always_comb begin
        w_stateNext    = r_state;
        w_cntNext      = r_cnt;
        w_highLenNext  = r_highLen;
        w_onCountNext  = r_onCount;
        w_offCountNext = r_offCount;
        w_periodNext   = r_period;
        w_validNext    = 1'b0;
        w_stalledNext  = r_stalled;

        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_stateNext   = MEAS_HIGH;
                    w_cntNext     = CNT_ONE;
                    w_stalledNext = 1'b0;
                end
            end
            MEAS_HIGH: begin
                if (w_fall) begin
                    w_highLenNext = r_cnt;
                    w_cntNext     = CNT_ONE;
                    w_stateNext   = MEAS_LOW;
                end else if (r_cnt == CNT_MAX) begin
                    w_stateNext   = IDLE;
                    w_stalledNext = 1'b1;
                end else begin
                    w_cntNext = r_cnt + CNT_ONE;
                end
            end
            MEAS_LOW: begin
                if (w_rise) begin
                    w_onCountNext  = r_highLen;
                    w_offCountNext = r_cnt;
                    w_periodNext   = {1'b0, r_highLen} + {1'b0, r_cnt};
                    w_validNext    = 1'b1;
                    w_cntNext      = CNT_ONE;
                    w_stateNext    = MEAS_HIGH;
                end else if (r_cnt == CNT_MAX) begin
                    w_stateNext   = IDLE;
                    w_stalledNext = 1'b1;
                end else begin
                    w_cntNext = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign on_count_o  = r_onCount;
    assign off_count_o = r_offCount;
    assign period_o    = r_period;
    assign valid_o     = r_valid;
    assign stalled_o   = r_stalled;

endmodule

// File: tb/tb_square_wave_duty_meter.sv
// Directed self-checking bench for square_wave_duty_meter with CNT_WIDTH=12, SYNC_STAGES=2.
module tb_square_wave_duty_meter;

    localparam int CNT_WIDTH   = 12;
    localparam int SYNC_STAGES = 2;

    logic                 clk_i;
    logic                 rst_i;
    logic                 square_wave_i;
    logic [CNT_WIDTH-1:0] on_count_o;
    logic [CNT_WIDTH-1:0] off_count_o;
    logic [CNT_WIDTH:0]   period_o;
    logic                 valid_o;
    logic                 stalled_o;

    int checkCount;
    int failCount;
    int totalValid;
    int validBase;

    square_wave_duty_meter #(
        .CNT_WIDTH   (CNT_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .square_wave_i (square_wave_i),
        .on_count_o    (on_count_o),
        .off_count_o   (off_count_o),
        .period_o      (period_o),
        .valid_o       (valid_o),
        .stalled_o     (stalled_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Counts valid pulses one cycle at a time, so a stuck-high valid inflates the count.
    always @(posedge clk_i) begin
        #1;
        if (valid_o === 1'b1) totalValid = totalValid + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount = checkCount + 1;
        if (actual !== expected) begin
            failCount = failCount + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Holds the input at a level for a whole number of clock cycles, starting on a falling edge.
    task automatic applyStimulus(input logic level, input int cycles);
        square_wave_i = level;
        repeat (cycles) @(negedge clk_i);
    endtask

    task automatic applyReset(input logic level, input int cycles);
        square_wave_i = level;
        rst_i = 1'b1;
        repeat (cycles) @(negedge clk_i);
        rst_i = 1'b0;
        validBase = totalValid;
    endtask

    task automatic checkReport(input string tag, input int nValid, input int onVal, input int offVal);
        checkOutput({tag, "_count"}, totalValid - validBase, nValid);
        checkOutput({tag, "_on"}, on_count_o, onVal);
        checkOutput({tag, "_off"}, off_count_o, offVal);
        checkOutput({tag, "_period"}, period_o, onVal + offVal);
    endtask

    initial begin
        checkCount    = 0;
        failCount     = 0;
        totalValid    = 0;
        validBase     = 0;
        rst_i         = 1'b1;
        square_wave_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checkOutput("rst_on", on_count_o, 0);
        checkOutput("rst_off", off_count_o, 0);
        checkOutput("rst_period", period_o, 0);
        checkOutput("rst_valid", valid_o, 0);
        checkOutput("rst_stalled", stalled_o, 0);
        rst_i = 1'b0;
        validBase = totalValid;

        // 10/10 repeated: nothing before the second rise, then one report per period.
        applyStimulus(1'b0, 5);
        applyStimulus(1'b1, 10);
        applyStimulus(1'b0, 10);
        checkOutput("p10_first", totalValid - validBase, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 10);
            applyStimulus(1'b0, 10);
        end
        applyStimulus(1'b1, 10);
        checkReport("p10", 4, 10, 10);

        // 30/70, then a switch to 50/50 leaves one mixed period.
        applyReset(1'b0, 2);
        applyStimulus(1'b0, 5);
        applyStimulus(1'b1, 30);
        applyStimulus(1'b0, 70);
        applyStimulus(1'b1, 30);
        applyStimulus(1'b0, 70);
        applyStimulus(1'b1, 30);
        checkReport("p30", 2, 30, 70);
        applyStimulus(1'b0, 50);
        applyStimulus(1'b1, 50);
        checkReport("mixed", 3, 30, 50);
        applyStimulus(1'b0, 50);
        applyStimulus(1'b1, 50);
        checkReport("p50", 4, 50, 50);

        // Stuck high: stall one cycle after the counter reaches 4095, outputs kept.
        applyReset(1'b0, 2);
        applyStimulus(1'b0, 5);
        applyStimulus(1'b1, 20);
        applyStimulus(1'b0, 30);
        applyStimulus(1'b1, 20);
        applyStimulus(1'b0, 30);
        applyStimulus(1'b1, 4097);
        checkOutput("stall_early", stalled_o, 0);
        applyStimulus(1'b1, 1);
        checkOutput("stall_set", stalled_o, 1);
        applyStimulus(1'b1, 902);
        checkReport("stall_hold", 2, 20, 30);
        checkOutput("stall_level", stalled_o, 1);
        applyStimulus(1'b0, 10);
        checkOutput("stall_fall", stalled_o, 1);
        applyStimulus(1'b1, 10);
        checkOutput("stall_clear", stalled_o, 0);
        checkOutput("stall_noval", totalValid - validBase, 2);
        applyStimulus(1'b0, 10);
        applyStimulus(1'b1, 10);
        checkReport("rearm", 3, 10, 10);

        // Low phase of exactly the counter maximum is recorded, not treated as a stall.
        applyReset(1'b0, 2);
        applyStimulus(1'b0, 5);
        applyStimulus(1'b1, 10);
        applyStimulus(1'b0, 4095);
        applyStimulus(1'b1, 10);
        checkReport("lowmax", 1, 10, 4095);
        checkOutput("lowmax_stall", stalled_o, 0);

        // Input high across reset release must not look like a rise.
        applyReset(1'b1, 3);
        applyStimulus(1'b1, 20);
        checkOutput("rsthigh_none", totalValid - validBase, 0);
        applyStimulus(1'b0, 10);
        applyStimulus(1'b1, 10);
        checkOutput("rsthigh_part", totalValid - validBase, 0);
        applyStimulus(1'b0, 10);
        applyStimulus(1'b1, 10);
        checkReport("rsthigh", 1, 10, 10);

        // One-cycle reset in the middle of a high phase abandons that period.
        applyStimulus(1'b1, 5);
        rst_i = 1'b1;
        @(negedge clk_i);
        checkOutput("midrst_on", on_count_o, 0);
        checkOutput("midrst_off", off_count_o, 0);
        checkOutput("midrst_period", period_o, 0);
        rst_i = 1'b0;
        validBase = totalValid;
        applyStimulus(1'b1, 10);
        applyStimulus(1'b0, 15);
        applyStimulus(1'b1, 12);
        applyStimulus(1'b0, 8);
        checkOutput("midrst_none", totalValid - validBase, 0);
        applyStimulus(1'b1, 5);
        checkReport("midrst", 1, 12, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/square_wave_duty_meter.md
SQUARE_WAVE_DUTY_METER -- requirements
Module: square_wave_duty_meter

Interface
REQ-001 Parameter CNT_WIDTH, default 12, is the width of the high/low duration counters, in clock cycles.
REQ-002 Parameter SYNC_STAGES, default 2, is the number of input synchronizer flops; legal range is 2 to 4.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset; synchronous and active-high.
REQ-005 square_wave_i  input  1  square wave under measurement; asynchronous to clk_i.
REQ-006 on_count_o  output  CNT_WIDTH  high duration of the last complete period, in clk cycles.
REQ-007 off_count_o  output  CNT_WIDTH  low duration of the last complete period, in clk cycles.
REQ-008 period_o  output  CNT_WIDTH+1  on_count_o + off_count_o, registered alongside them, with no truncation.
REQ-009 valid_o  output  1  one-cycle pulse marking new values on on_count_o, off_count_o and period_o.
REQ-010 stalled_o  output  1  level; high while the input is stuck or the meter is re-arming after a stall.

Function
REQ-011 square_wave_i SHALL pass through SYNC_STAGES flops to give s, and s SHALL be delayed one flop to give s_d.
REQ-012 Edge definitions: rise = s & ~s_d; fall = ~s & s_d.
REQ-013 FSM states SHALL be IDLE, MEAS_HIGH and MEAS_LOW; the reset state is IDLE.
REQ-014 IDLE: on rise -> MEAS_HIGH with cnt <= 1; fall is ignored; no other transitions.
REQ-015 MEAS_HIGH, no edge: cnt <= cnt + 1.
REQ-016 MEAS_HIGH, on fall: high_len <= cnt; cnt <= 1; -> MEAS_LOW.
REQ-017 MEAS_LOW, no edge: cnt <= cnt + 1.
REQ-018 MEAS_LOW, on rise: on_count_o <= high_len; off_count_o <= cnt; period_o <= high_len + cnt; valid_o <= 1 for exactly one cycle; cnt <= 1; -> MEAS_HIGH.
REQ-019 A count SHALL equal the number of cycles s held the level; a 10-cycle high followed by a 10-cycle low yields on=10, off=10, period=20.
REQ-020 Latency: valid_o SHALL assert SYNC_STAGES+1 clk edges after the first edge that samples square_wave_i high at a completing rise.
REQ-021 Saturation: if cnt == 2^CNT_WIDTH-1 and no edge occurs in MEAS_HIGH or MEAS_LOW -> IDLE; stalled_o <= 1; cnt holds; outputs retain their previous values; no valid_o.
REQ-022 Simultaneous edge and cnt == max: the edge SHALL take priority and the saturated value SHALL be recorded normally.
REQ-023 stalled_o SHALL clear on the first rise seen in IDLE.
REQ-024 After any entry to IDLE, the first valid_o SHALL follow only one complete high+low period; partial periods are never reported.
REQ-025 Input pulses shorter than one clk cycle may be missed, and the meter SHALL NOT report them or treat them as errors.
REQ-026 All outputs SHALL be registered, with no combinational path from square_wave_i.

Reset
REQ-027 While rst_i = 1: state = IDLE; cnt = 0; high_len = 0; on_count_o, off_count_o and period_o = 0; valid_o = 0; stalled_o = 0.
REQ-028 While rst_i = 1, the synchronizer flops and s_d SHALL reset to 1, so an input already high at reset release does not produce a spurious rise.
REQ-029 rst_i asserted mid-measurement SHALL abandon the period in progress; the next valid_o follows a full period after release.

Verification
REQ-030 Drive 10 cycles high / 10 low, repeated -> first valid_o after the second rise; on=10, off=10, period=20; valid_o exactly once per period.
REQ-031 Drive 30 high / 70 low -> on=30, off=70, period=100; switch to 50/50 mid-stream -> the next report is a mixed period (the high it completes belongs to the old pattern); subsequent reports are 50/50.
REQ-032 Hold the input high for 5000 cycles with CNT_WIDTH=12 -> stalled_o rises the cycle after cnt reaches 4095; outputs unchanged; no valid_o; apply 10/10 -> stalled_o clears at the rise; the first valid_o reports 10/10.
REQ-033 Input high during and after reset release -> no rise detected, no valid_o; the first report comes after a full following period.
REQ-034 Assert rst_i for 1 cycle mid-high -> all outputs return to 0; the next valid_o reports a correct complete period.
REQ-035 Low phase of exactly 4095 cycles ending in a rise -> valid_o with off=4095 and stalled_o remains 0.
